load_store_unit: RTL
====================

# load_store_unit

Initiator-side access controller for the word-organised data memory of the single-cycle RISC-V datapath. Takes byte-addressed RV32I load/store requests over a valid/ready handshake and drives the memory's address, write-enable and write-data pins. Performs little-endian byte-lane selection with sign/zero extension on loads, and read-modify-write for SB/SH. Flags misaligned, illegal-funct3 and out-of-range accesses without touching memory.

## Interface
- MEM_WORDS, 1024: number of 32-bit words in the attached memory; valid word index range 0..MEM_WORDS-1.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  1 = access rejected, memory untouched.
- mem_addr  out  32  word index to memory = {2'b00, addr[31:2]}.
- mem_we  out  1  memory write enable (memory writes on rising clk).
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_addr.

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, capture store, funct3, addr, wdata. Then decode:
  - err if funct3 illegal (load: 011/110/111; store: any other than 000/001/010);
  - err if halfword with addr[0]=1 or word with addr[1:0]≠00;
  - err if addr[31:2] ≥ MEM_WORDS.
  - Error → RESP with resp_err=1. Load → LOAD. SW → WRITE. SB/SH → RMW_RD.
- LOAD: drive mem_addr and mem_we=0. Register extracted data into resp_rdata: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. Then → RESP.
- RMW_RD: drive mem_addr and mem_we=0. Register mem_rd into an internal old-word register. Then → WRITE.
- WRITE: for exactly one cycle, drive mem_addr, mem_we=1 and mem_wd. For SW, mem_wd = wdata. For SB/SH, mem_wd = old word with the selected byte/half lane replaced by wdata[7:0]/wdata[15:0]; all other lanes unchanged. Then → RESP.
- RESP: resp_valid=1. Hold resp_rdata and resp_err stable until resp_ready=1, then → IDLE. No new request is accepted in the same cycle; req_ready rises the following cycle.
- mem_we is high only in WRITE. In every other state mem_we=0 and mem_wd=0. mem_addr holds the captured word index outside IDLE and is 0 in IDLE.

## Timing
- Reset (async assert, sync release) forces: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_we=0, mem_wd=0.
- Latency from the accept edge (cycle T) to first resp_valid cycle: load T+2; SW T+2; SB/SH T+3; error T+1.
- Memory write commits on the rising edge that ends the WRITE cycle. A load issued after the response is accepted observes the new data.
- resp_ready held high gives throughput of one access per (latency+1) cycles.
- Reset asserted mid-operation aborts immediately: mem_we drops asynchronously. A partially-completed RMW does not write, and the pending response is discarded.
- resp_ready high while resp_valid is low has no effect. req_valid outside IDLE is ignored; no request is queued.

## Test plan
- Write 0x00000020 with SW @0x70, then LW @0x70 → resp_rdata=0x00000020, resp_err=0. mem_we is high for exactly one cycle, with mem_addr=0x1C during that cycle.
- Write 0x80FF7F01 with SW @0x40; then LB @0x43 → 0xFFFFFF80; LBU @0x43 → 0x00000080; LH @0x42 → 0xFFFF80FF; LHU @0x40 → 0x00007F01.
- Write 0x11223344 with SW @0x20; then SB wdata=0xAA @0x21 (RMW, response at T+3); then LW @0x20 → 0x1122AA44. Follow with SH wdata=0xBEEF @0x22, then LW → 0xBEEFAA44.
- LW @0x02, LH @0x01, LB funct3=011, and SW @0x1000 (MEM_WORDS=1024) → each gives resp_err=1 and resp_rdata=0 at T+1; mem_we stays 0 throughout.
- Hold resp_ready=0 for 5 cycles after an LW → resp_valid and resp_rdata stay stable and req_ready stays 0. Raise resp_ready → IDLE next cycle.
- Assert rst during the RMW_RD cycle of SB @0x21 → all outputs return to reset values with no memory write; a subsequent LW @0x20 returns the pre-SB word.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store access controller for a word-organised data memory
// Byte-lane extraction on loads, read-modify-write for SB/SH, error rejection without memory access.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  state_t      state;
  logic [2:0]  cap_f3;
  logic [1:0]  cap_off;
  logic [15:0] cap_wdata;

  logic        f3_ok;
  logic        align_ok;
  logic        range_ok;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Request decode, evaluated on the incoming request while in IDLE.
  always_comb begin
    if (req_store) begin
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      f3_ok = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
    end
    case (req_funct3[1:0])
      2'b01:   align_ok = ~req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = {2'b00, req_addr[31:2]} < MEM_WORDS_W;
    req_err  = ~(f3_ok & align_ok & range_ok);
  end

  // Lane extraction for loads from the word currently on mem_rd.
  always_comb begin
    case (cap_off)
      2'b00:   lane_b = mem_rd[7:0];
      2'b01:   lane_b = mem_rd[15:8];
      2'b10:   lane_b = mem_rd[23:16];
      default: lane_b = mem_rd[31:24];
    endcase
    lane_h = cap_off[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (cap_f3)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {24'h0, lane_b};
      3'b101:  load_data = {16'h0, lane_h};
      default: load_data = mem_rd;
    endcase
  end

  // Sub-word store merge: old word with only the addressed lane replaced.
  always_comb begin
    merged = mem_rd;
    if (cap_f3[1:0] == 2'b00) begin
      case (cap_off)
        2'b00:   merged[7:0]   = cap_wdata[7:0];
        2'b01:   merged[15:8]  = cap_wdata[7:0];
        2'b10:   merged[23:16] = cap_wdata[7:0];
        default: merged[31:24] = cap_wdata[7:0];
      endcase
    end else if (cap_off[1]) begin
      merged[31:16] = cap_wdata;
    end else begin
      merged[15:0] = cap_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cap_f3     <= 3'b000;
      cap_off    <= 2'b00;
      cap_wdata  <= 16'h0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_addr   <= 32'h0;
      mem_we     <= 1'b0;
      mem_wd     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_f3    <= req_funct3;
            cap_off   <= req_addr[1:0];
            cap_wdata <= req_wdata[15:0];
            req_ready <= 1'b0;
            mem_addr  <= {2'b00, req_addr[31:2]};
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              state      <= RESP;
            end else if (!req_store) begin
              state <= LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              mem_we <= 1'b1;
              mem_wd <= req_wdata;
              state  <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          mem_wd <= merged;
          mem_we <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          mem_we     <= 1'b0;
          mem_wd     <= 32'h0;
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            mem_addr   <= 32'h0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
